// File: rtl/keypad_code_entry.sv
// Keypad front end: debounces a one-hot 4-key pad on ENA ticks, assembles a CODE_LEN-digit code, checks it against PIN.
// Latency: key_valid/code_ok/code_bad are registered, asserted on the clk edge that evaluates the accepting ENA sample.
// Backpressure: none; pulses are one clk wide and must be consumed by the alarm FSM when they occur.
module keypad_code_entry #(
    parameter int                      CODE_LEN       = 4,
    parameter logic [2*CODE_LEN-1:0]   PIN            = 8'hE4,
    parameter int                      DEBOUNCE_TICKS = 3,
    parameter int                      TIMEOUT_TICKS  = 20,
    parameter int                      MAX_FAIL       = 3,
    parameter int                      LOCK_TICKS     = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ENA,
    input  logic [3:0] keypad,
    output logic       key_valid,
    output logic [1:0] key_digit,
    output logic       code_ok,
    output logic       code_bad,
    output logic       entry_busy,
    output logic       locked
);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int LW = $clog2(LOCK_TICKS + 1);
    localparam int IW = $clog2(CODE_LEN + 1);

    localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE_TICKS);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_TICKS);
    localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_TICKS);
    localparam logic [IW-1:0] IDX_LAST = IW'(CODE_LEN - 1);

    typedef enum logic [2:0] {
        IDLE, DEB_PRESS, HELD, DEB_RELEASE, LOCKOUT
    } state_t;

    state_t                state, state_nxt;
    logic [3:0]            cand, cand_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [2*CODE_LEN-1:0] code, code_nxt;
    logic [FW-1:0]         fail, fail_nxt;
    logic [TW-1:0]         to_cnt, to_nxt;
    logic [LW-1:0]         lock_cnt, lock_nxt;
    logic                  accept;
    logic [1:0]            acc_digit, digit_nxt;
    logic                  valid_nxt, ok_nxt, bad_nxt;
    logic                  key_none, key_one;

    function automatic logic [1:0] enc(input logic [3:0] k);
        logic [1:0] d;
        d = 2'd0;
        for (int i = 0; i < 4; i++)
            if (k[i]) d = 2'(i);
        return d;
    endfunction

    assign key_none = (keypad == 4'd0);
    assign key_one  = !key_none && ((keypad & (keypad - 4'd1)) == 4'd0);

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        code_nxt  = code;
        fail_nxt  = fail;
        to_nxt    = to_cnt;
        lock_nxt  = lock_cnt;
        accept    = 1'b0;
        acc_digit = enc(cand);
        digit_nxt = key_digit;
        valid_nxt = 1'b0;
        ok_nxt    = 1'b0;
        bad_nxt   = 1'b0;

        if (idx == '0)
            to_nxt = '0;

        if (ENA) begin
            case (state)
                IDLE: begin
                    if (key_one) begin
                        cand_nxt  = keypad;
                        acc_digit = enc(keypad);
                        if (DEBOUNCE_TICKS <= 1) begin
                            accept = 1'b1;
                        end else begin
                            state_nxt = DEB_PRESS;
                            cnt_nxt   = CW'(1);
                        end
                    end
                end
                DEB_PRESS: begin
                    if (keypad == cand) begin
                        if (cnt + 1'b1 >= DEB_MAX) accept = 1'b1;
                        else                       cnt_nxt = cnt + 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                HELD: begin
                    if (key_none) begin
                        if (DEBOUNCE_TICKS <= 1) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = DEB_RELEASE;
                            cnt_nxt   = CW'(1);
                        end
                    end
                end
                DEB_RELEASE: begin
                    if (!key_none)                 state_nxt = HELD;
                    else if (cnt + 1'b1 >= DEB_MAX) state_nxt = IDLE;
                    else                           cnt_nxt = cnt + 1'b1;
                end
                LOCKOUT: begin
                    if (lock_cnt + 1'b1 >= LOCK_MAX) begin
                        state_nxt = HELD;
                        lock_nxt  = '0;
                        fail_nxt  = '0;
                    end else begin
                        lock_nxt = lock_cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase

            // A stale partial entry is dropped silently once the idle window runs out
            if (state == IDLE && idx != '0 && !accept) begin
                if (to_cnt + 1'b1 >= TO_MAX) begin
                    idx_nxt = '0;
                    to_nxt  = '0;
                end else begin
                    to_nxt = to_cnt + 1'b1;
                end
            end
        end

        if (accept) begin
            state_nxt = HELD;
            valid_nxt = 1'b1;
            digit_nxt = acc_digit;
            to_nxt    = '0;
            for (int i = 0; i < CODE_LEN; i++)
                if (idx == IW'(i)) code_nxt[2*i +: 2] = acc_digit;
            if (idx >= IDX_LAST) begin
                idx_nxt = '0;
                if (code_nxt == PIN) begin
                    ok_nxt   = 1'b1;
                    fail_nxt = '0;
                end else begin
                    bad_nxt  = 1'b1;
                    fail_nxt = fail + 1'b1;
                    if (fail + 1'b1 >= FAIL_MAX) begin
                        state_nxt = LOCKOUT;
                        lock_nxt  = '0;
                    end
                end
            end else begin
                idx_nxt = idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cand       <= '0;
            cnt        <= '0;
            idx        <= '0;
            code       <= '0;
            fail       <= '0;
            to_cnt     <= '0;
            lock_cnt   <= '0;
            key_valid  <= 1'b0;
            key_digit  <= 2'd0;
            code_ok    <= 1'b0;
            code_bad   <= 1'b0;
            entry_busy <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cand       <= cand_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            code       <= code_nxt;
            fail       <= fail_nxt;
            to_cnt     <= to_nxt;
            lock_cnt   <= lock_nxt;
            key_valid  <= valid_nxt;
            key_digit  <= digit_nxt;
            code_ok    <= ok_nxt;
            code_bad   <= bad_nxt;
            entry_busy <= (idx_nxt != '0);
            locked     <= (state_nxt == LOCKOUT);
        end
    end
endmodule

// File: tb/tb_keypad_code_entry.sv
// Bench for keypad_code_entry: directed keypad sequences, expected key/code events queued and checked by a monitor.
module tb_keypad_code_entry;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ENA = 1'b0;
    logic [3:0] keypad = 4'd0;
    logic       key_valid, code_ok, code_bad, entry_busy, locked;
    logic [1:0] key_digit;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0] digit;
        logic       ok;
        logic       bad;
        logic       lk;
        logic       busy;
    } ev_t;

    ev_t sb[$];
    ev_t act_ev, exp_ev;

    keypad_code_entry dut (
        .clk        (clk),
        .reset      (reset),
        .ENA        (ENA),
        .keypad     (keypad),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .code_ok    (code_ok),
        .code_bad   (code_bad),
        .entry_busy (entry_busy),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    // Monitor: every output event must match the oldest queued expectation
    always @(negedge clk) begin
        if (reset && (key_valid || code_ok || code_bad)) begin
            act_ev = '{digit: key_digit, ok: code_ok, bad: code_bad, lk: locked, busy: entry_busy};
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event got digit=%0d ok=%0b bad=%0b locked=%0b busy=%0b, expected no event",
                         act_ev.digit, act_ev.ok, act_ev.bad, act_ev.lk, act_ev.busy);
            end else begin
                exp_ev = sb.pop_front();
                if (act_ev !== exp_ev || !key_valid) begin
                    failures++;
                    $display("FAIL event got valid=%0b digit=%0d ok=%0b bad=%0b locked=%0b busy=%0b, expected valid=1 digit=%0d ok=%0b bad=%0b locked=%0b busy=%0b",
                             key_valid, act_ev.digit, act_ev.ok, act_ev.bad, act_ev.lk, act_ev.busy,
                             exp_ev.digit, exp_ev.ok, exp_ev.bad, exp_ev.lk, exp_ev.busy);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time budget");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic [3:0] k);
        @(negedge clk);
        keypad = k;
        repeat (3) @(negedge clk);
        ENA = 1'b1;
        @(negedge clk);
        ENA = 1'b0;
    endtask

    task automatic hold(input logic [3:0] k, input int n);
        for (int i = 0; i < n; i++) tick(k);
    endtask

    task automatic press(input int d);
        hold(4'(1 << d), 5);
        hold(4'd0, 5);
    endtask

    task automatic key(input int d, input bit ok, input bit bad, input bit lk, input bit busy);
        sb.push_back('{digit: 2'(d), ok: ok, bad: bad, lk: lk, busy: busy});
        press(d);
    endtask

    task automatic drain(input string name);
        repeat (2) @(negedge clk);
        #1;
        chk(name, sb.size(), 0);
    endtask

    initial begin
        #3;
        chk("reset_key_valid", key_valid, 0);
        chk("reset_key_digit", key_digit, 0);
        chk("reset_code_ok", code_ok, 0);
        chk("reset_code_bad", code_bad, 0);
        chk("reset_entry_busy", entry_busy, 0);
        chk("reset_locked", locked, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // 1: correct code 0,1,2,3
        key(0, 0, 0, 0, 1);
        key(1, 0, 0, 0, 1);
        key(2, 0, 0, 0, 1);
        key(3, 1, 0, 0, 0);
        chk("t1_entry_busy", entry_busy, 0);
        drain("t1_drain");

        // 2: bouncing key 1 then stable; leftover digit times out
        for (int i = 0; i < 10; i++) begin
            tick(4'b0010);
            tick(4'b0000);
        end
        drain("t2_no_bounce_accept");
        sb.push_back('{digit: 2'd1, ok: 1'b0, bad: 1'b0, lk: 1'b0, busy: 1'b1});
        hold(4'b0010, 3);
        hold(4'd0, 25);
        chk("t2_timeout_busy", entry_busy, 0);
        drain("t2_drain");

        // 3: partial entry expires at exactly TIMEOUT_TICKS idle ticks, then a wrong code
        key(0, 0, 0, 0, 1);
        key(1, 0, 0, 0, 1);
        hold(4'd0, 17);
        chk("t3_busy_before_timeout", entry_busy, 1);
        tick(4'd0);
        chk("t3_busy_after_timeout", entry_busy, 0);
        key(3, 0, 0, 0, 1);
        key(3, 0, 0, 0, 1);
        key(3, 0, 0, 0, 1);
        key(3, 0, 1, 0, 0);
        drain("t3_drain");

        // 4: correct code clears fail count, three wrong codes lock out
        key(0, 0, 0, 0, 1);
        key(1, 0, 0, 0, 1);
        key(2, 0, 0, 0, 1);
        key(3, 1, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            key(3, 0, 0, 0, 1);
            key(3, 0, 0, 0, 1);
            key(3, 0, 0, 0, 1);
            key(3, 0, 1, (c == 2), 0);
        end
        chk("t4_locked_after_third", locked, 1);
        for (int d = 0; d < 4; d++) press(d);
        hold(4'd0, 2);
        chk("t4_locked_at_49", locked, 1);
        tick(4'd0);
        chk("t4_unlocked_at_50", locked, 0);
        drain("t4_ignored_keys");
        hold(4'd0, 5);
        key(0, 0, 0, 0, 1);
        key(1, 0, 0, 0, 1);
        key(2, 0, 0, 0, 1);
        key(3, 1, 0, 0, 0);
        drain("t4_drain");

        // 5: multi-key rejected; new key while held not accepted until release debounced
        hold(4'b0011, 10);
        drain("t5_multi_ignored");
        sb.push_back('{digit: 2'd2, ok: 1'b0, bad: 1'b0, lk: 1'b0, busy: 1'b1});
        hold(4'b0100, 5);
        hold(4'b1000, 5);
        hold(4'd0, 2);
        hold(4'b1000, 5);
        hold(4'd0, 5);
        drain("t5_no_second_accept");
        sb.push_back('{digit: 2'd3, ok: 1'b0, bad: 1'b0, lk: 1'b0, busy: 1'b1});
        hold(4'b1000, 5);
        hold(4'd0, 25);
        chk("t5_timeout_busy", entry_busy, 0);
        drain("t5_drain");

        // 6: async reset mid-entry
        key(0, 0, 0, 0, 1);
        key(1, 0, 0, 0, 1);
        drain("t6_pre_reset");
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("t6_reset_busy", entry_busy, 0);
        chk("t6_reset_digit", key_digit, 0);
        chk("t6_reset_valid", key_valid, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        key(0, 0, 0, 0, 1);
        key(1, 0, 0, 0, 1);
        key(2, 0, 0, 0, 1);
        key(3, 1, 0, 0, 0);
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
